// File: rtl/commit_sequencer.sv
// commit_sequencer: in-order retire stage sitting behind order_queue.
// Tracks per-tag completion, destination register and result, and
// retires the queue head into the register file once its result is known.
`timescale 1ns/1ps

module commit_sequencer #(
    parameter int TAG_WIDTH  = 5,
    parameter int DEPTH      = 2 ** TAG_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  disp_valid,
    input  logic [TAG_WIDTH-1:0]  disp_tag,
    input  logic [REG_WIDTH-1:0]  disp_rd,
    input  logic                  cdb_valid,
    input  logic [TAG_WIDTH-1:0]  cdb_tag,
    input  logic [DATA_WIDTH-1:0] cdb_data,
    input  logic [TAG_WIDTH-1:0]  oq_tag,
    input  logic                  oq_empty,
    output logic                  oq_pop,
    output logic                  rf_we,
    output logic [REG_WIDTH-1:0]  rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [CNT_WIDTH-1:0]  retire_cnt,
    output logic                  err_dup
);

    typedef enum logic [1:0] {
        ST_CHECK  = 2'd0,
        ST_COMMIT = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH-1:0]      done_q, done_d;
    logic [REG_WIDTH-1:0]  rd_mem_q [DEPTH];
    logic [REG_WIDTH-1:0]  rd_mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] val_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] val_mem_d [DEPTH];
    logic [TAG_WIDTH-1:0]  head_tag_q, head_tag_d;
    logic [REG_WIDTH-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [CNT_WIDTH-1:0]  retire_cnt_q, retire_cnt_d;
    logic                  err_dup_q, err_dup_d;
    logic                  commit_clear;

    // Retire FSM: wait for the head to complete, commit it for one cycle,
    // then idle one cycle so order_queue can present its new head.
    always_comb begin
        state_d      = state_q;
        head_tag_d   = head_tag_q;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        retire_cnt_d = retire_cnt_q;
        oq_pop       = 1'b0;
        rf_we        = 1'b0;
        commit_clear = 1'b0;
        case (state_q)
            ST_CHECK: begin
                if (!oq_empty && done_q[oq_tag]) begin
                    rf_waddr_d = rd_mem_q[oq_tag];
                    rf_wdata_d = val_mem_q[oq_tag];
                    head_tag_d = oq_tag;
                    state_d    = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                oq_pop       = 1'b1;
                rf_we        = (rf_waddr_q != '0);
                commit_clear = 1'b1;
                retire_cnt_d = retire_cnt_q + CNT_WIDTH'(1);
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                state_d = ST_CHECK;
            end
            default: begin
                state_d = ST_CHECK;
            end
        endcase
    end

    // Scoreboard update: CDB sets done, then the commit clear and the
    // dispatch clear override it; any same-tag conflict raises err_dup.
    always_comb begin
        done_d    = done_q;
        err_dup_d = err_dup_q;
        rd_mem_d  = rd_mem_q;
        val_mem_d = val_mem_q;
        if (cdb_valid) begin
            val_mem_d[cdb_tag] = cdb_data;
            if (done_q[cdb_tag]) begin
                err_dup_d = 1'b1;
            end
            if (disp_valid && (disp_tag == cdb_tag)) begin
                err_dup_d = 1'b1;
            end else if (commit_clear && (head_tag_q == cdb_tag)) begin
                err_dup_d = 1'b1;
            end else begin
                done_d[cdb_tag] = 1'b1;
            end
        end
        if (commit_clear) begin
            done_d[head_tag_q] = 1'b0;
        end
        if (disp_valid) begin
            rd_mem_d[disp_tag] = disp_rd;
            done_d[disp_tag]   = 1'b0;
        end
    end

    // Control and status registers, cleared by synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_CHECK;
            done_q       <= '0;
            head_tag_q   <= '0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            retire_cnt_q <= '0;
            err_dup_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            head_tag_q   <= head_tag_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            retire_cnt_q <= retire_cnt_d;
            err_dup_q    <= err_dup_d;
        end
    end

    // Per-tag destination and result storage; contents need no reset
    // because done gates every read.
    always_ff @(posedge clock) begin
        rd_mem_q  <= rd_mem_d;
        val_mem_q <= val_mem_d;
    end

    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign retire_cnt = retire_cnt_q;
    assign err_dup    = err_dup_q;

endmodule

// File: tb/tb_commit_sequencer.sv
// Directed self-checking bench for commit_sequencer.
`timescale 1ns/1ps

module tb_commit_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        disp_valid;
    logic [4:0]  disp_tag;
    logic [4:0]  disp_rd;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [4:0]  oq_tag;
    logic        oq_empty;
    logic        oq_pop;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] retire_cnt;
    logic        err_dup;

    // second instance with a narrow counter for the wrap test
    logic        w_disp_valid;
    logic [4:0]  w_disp_tag;
    logic [4:0]  w_disp_rd;
    logic        w_cdb_valid;
    logic [4:0]  w_cdb_tag;
    logic [31:0] w_cdb_data;
    logic [4:0]  w_oq_tag;
    logic        w_oq_empty;
    logic        w_oq_pop;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata;
    logic [3:0]  w_retire_cnt;
    logic        w_err_dup;

    int checks = 0;
    int errors = 0;

    commit_sequencer dut (
        .clock(clock), .reset(reset),
        .disp_valid(disp_valid), .disp_tag(disp_tag), .disp_rd(disp_rd),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .oq_tag(oq_tag), .oq_empty(oq_empty), .oq_pop(oq_pop),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire_cnt(retire_cnt), .err_dup(err_dup)
    );

    commit_sequencer #(.CNT_WIDTH(4)) dut_wrap (
        .clock(clock), .reset(reset),
        .disp_valid(w_disp_valid), .disp_tag(w_disp_tag), .disp_rd(w_disp_rd),
        .cdb_valid(w_cdb_valid), .cdb_tag(w_cdb_tag), .cdb_data(w_cdb_data),
        .oq_tag(w_oq_tag), .oq_empty(w_oq_empty), .oq_pop(w_oq_pop),
        .rf_we(w_rf_we), .rf_waddr(w_rf_waddr), .rf_wdata(w_rf_wdata),
        .retire_cnt(w_retire_cnt), .err_dup(w_err_dup)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        disp_valid = 1'b0; disp_tag = '0; disp_rd = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        oq_tag = '0; oq_empty = 1'b1;
        w_disp_valid = 1'b0; w_disp_tag = '0; w_disp_rd = '0;
        w_cdb_valid = 1'b0; w_cdb_tag = '0; w_cdb_data = '0;
        w_oq_tag = '0; w_oq_empty = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // steps until oq_pop is seen; returns sampled in the COMMIT cycle
    task automatic wait_pop(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (oq_pop === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s: oq_pop got 0 for 8 cycles, expected 1", name);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (oq_pop !== 1'b0 || rf_we !== 1'b0 || retire_cnt !== 16'd0 || err_dup !== 1'b0 ||
            rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_values: pop=%b we=%b cnt=%h err=%b waddr=%h wdata=%h, expected all 0",
                     oq_pop, rf_we, retire_cnt, err_dup, rf_waddr, rf_wdata);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (oq_pop !== 1'b0 || rf_we !== 1'b0 || retire_cnt !== 16'd0 || err_dup !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_cycle%0d: pop=%b we=%b cnt=%h err=%b, expected 0 0 0000 0",
                         i, oq_pop, rf_we, retire_cnt, err_dup);
            end
        end
    endtask

    task automatic test_single_retire();
        do_reset();
        disp_valid = 1'b1; disp_tag = 5'd3; disp_rd = 5'd7;
        step();
        disp_valid = 1'b0;
        oq_tag = 5'd3; oq_empty = 1'b0;
        step();
        checks++;
        if (oq_pop !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_no_early_pop: oq_pop got %b expected 0", oq_pop);
        end
        cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_data = 32'hDEADBEEF;
        step();
        cdb_valid = 1'b0;
        checks++;
        if (oq_pop !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_latency1: oq_pop got %b expected 0", oq_pop);
        end
        step();
        checks++;
        if (oq_pop !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_latency2: oq_pop got %b expected 1", oq_pop);
        end
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL single_write: we=%b waddr=%0d wdata=%h expected 1 7 deadbeef",
                     rf_we, rf_waddr, rf_wdata);
        end
        oq_empty = 1'b1;
        step();
        checks++;
        if (oq_pop !== 1'b0 || rf_we !== 1'b0 || retire_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL single_after: pop=%b we=%b cnt=%0d expected 0 0 1", oq_pop, rf_we, retire_cnt);
        end
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            disp_valid = 1'b1; disp_tag = 5'(i); disp_rd = 5'(i + 1);
            step();
        end
        disp_valid = 1'b0;
        oq_tag = 5'd0; oq_empty = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd2; cdb_data = 32'h22;
        step();
        cdb_tag = 5'd1; cdb_data = 32'h11;
        step();
        cdb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (oq_pop !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ooo_hold%0d: oq_pop got %b expected 0 before tag 0 completes", i, oq_pop);
            end
        end
        cdb_valid = 1'b1; cdb_tag = 5'd0; cdb_data = 32'h0;
        step();
        cdb_valid = 1'b0;
        wait_pop("ooo_pop0");
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL ooo_write0: we=%b waddr=%0d wdata=%h expected 1 1 00000000", rf_we, rf_waddr, rf_wdata);
        end
        oq_tag = 5'd1;
        wait_pop("ooo_pop1");
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h11) begin
            errors++;
            $display("[TB] FAIL ooo_write1: we=%b waddr=%0d wdata=%h expected 1 2 00000011", rf_we, rf_waddr, rf_wdata);
        end
        oq_tag = 5'd2;
        wait_pop("ooo_pop2");
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h22) begin
            errors++;
            $display("[TB] FAIL ooo_write2: we=%b waddr=%0d wdata=%h expected 1 3 00000022", rf_we, rf_waddr, rf_wdata);
        end
        oq_empty = 1'b1;
        step();
        checks++;
        if (retire_cnt !== 16'd3) begin
            errors++;
            $display("[TB] FAIL ooo_count: retire_cnt got %0d expected 3", retire_cnt);
        end
    endtask

    task automatic test_zero_dest();
        do_reset();
        disp_valid = 1'b1; disp_tag = 5'd5; disp_rd = 5'd0;
        step();
        disp_valid = 1'b0;
        oq_tag = 5'd5; oq_empty = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd5; cdb_data = 32'h55;
        step();
        cdb_valid = 1'b0;
        wait_pop("zero_pop");
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_no_write: rf_we got %b expected 0", rf_we);
        end
        oq_empty = 1'b1;
        step();
        checks++;
        if (retire_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL zero_count: retire_cnt got %0d expected 1", retire_cnt);
        end
    endtask

    task automatic test_errors();
        do_reset();
        cdb_valid = 1'b1; cdb_tag = 5'd4; cdb_data = 32'h1;
        step();
        checks++;
        if (err_dup !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dup_first: err_dup got %b expected 0", err_dup);
        end
        cdb_data = 32'h2;
        step();
        cdb_valid = 1'b0;
        checks++;
        if (err_dup !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dup_second: err_dup got %b expected 1", err_dup);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (err_dup !== 1'b1) begin
                errors++;
                $display("[TB] FAIL dup_sticky%0d: err_dup got %b expected 1", i, err_dup);
            end
        end

        do_reset();
        checks++;
        if (err_dup !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dup_reset_clear: err_dup got %b expected 0", err_dup);
        end
        disp_valid = 1'b1; disp_tag = 5'd9; disp_rd = 5'd12;
        cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'h77;
        step();
        disp_valid = 1'b0; cdb_valid = 1'b0;
        checks++;
        if (err_dup !== 1'b1) begin
            errors++;
            $display("[TB] FAIL disp_cdb_err: err_dup got %b expected 1", err_dup);
        end
        oq_tag = 5'd9; oq_empty = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (oq_pop !== 1'b0) begin
                errors++;
                $display("[TB] FAIL disp_cdb_not_done%0d: oq_pop got %b expected 0", i, oq_pop);
            end
        end
        cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'h99;
        step();
        cdb_valid = 1'b0;
        wait_pop("disp_cdb_later_pop");
        checks++;
        if (rf_waddr !== 5'd12 || rf_wdata !== 32'h99) begin
            errors++;
            $display("[TB] FAIL disp_cdb_later_write: waddr=%0d wdata=%h expected 12 00000099", rf_waddr, rf_wdata);
        end
        oq_empty = 1'b1;
        step();
    endtask

    task automatic test_commit_cdb_collision();
        do_reset();
        disp_valid = 1'b1; disp_tag = 5'd10; disp_rd = 5'd4;
        step();
        disp_valid = 1'b0;
        oq_tag = 5'd10; oq_empty = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd10; cdb_data = 32'hA0;
        step();
        cdb_valid = 1'b0;
        wait_pop("collide_pop");
        cdb_valid = 1'b1; cdb_tag = 5'd10; cdb_data = 32'hAA;
        step();
        cdb_valid = 1'b0;
        checks++;
        if (err_dup !== 1'b1 || retire_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL collide_err: err_dup=%b cnt=%0d expected 1 1", err_dup, retire_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (oq_pop !== 1'b0) begin
                errors++;
                $display("[TB] FAIL collide_cleared%0d: oq_pop got %b expected 0", i, oq_pop);
            end
        end
        oq_empty = 1'b1;
    endtask

    task automatic test_reset_mid_commit();
        do_reset();
        disp_valid = 1'b1; disp_tag = 5'd6; disp_rd = 5'd9;
        step();
        disp_valid = 1'b0;
        oq_tag = 5'd6; oq_empty = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd6; cdb_data = 32'h66;
        step();
        cdb_valid = 1'b0;
        step();
        checks++;
        if (oq_pop !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_in_commit: oq_pop got %b expected 1", oq_pop);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (oq_pop !== 1'b0 || rf_we !== 1'b0 || retire_cnt !== 16'd0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: pop=%b we=%b cnt=%0d waddr=%0d wdata=%h expected all 0",
                     oq_pop, rf_we, retire_cnt, rf_waddr, rf_wdata);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (oq_pop !== 1'b0 || retire_cnt !== 16'd0) begin
                errors++;
                $display("[TB] FAIL midreset_after%0d: pop=%b cnt=%0d expected 0 0", i, oq_pop, retire_cnt);
            end
        end
        oq_empty = 1'b1;
    endtask

    task automatic test_wrap();
        bit seen;
        do_reset();
        w_disp_valid = 1'b1; w_disp_tag = 5'd0; w_disp_rd = 5'd3;
        step();
        w_disp_valid = 1'b0;
        w_oq_tag = 5'd0; w_oq_empty = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            w_cdb_valid = 1'b1; w_cdb_tag = 5'd0; w_cdb_data = 32'(n);
            step();
            w_cdb_valid = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                step();
                if (w_oq_pop === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            checks++;
            if (!seen || w_rf_we !== 1'b1 || w_rf_waddr !== 5'd3 || w_rf_wdata !== 32'(n)) begin
                errors++;
                $display("[TB] FAIL wrap_commit%0d: seen=%b we=%b waddr=%0d wdata=%h expected 1 1 3 %h",
                         n, seen, w_rf_we, w_rf_waddr, w_rf_wdata, 32'(n));
            end
            step();
            if (n == 15) begin
                checks++;
                if (w_retire_cnt !== 4'd15) begin
                    errors++;
                    $display("[TB] FAIL wrap_pre: retire_cnt got %0d expected 15", w_retire_cnt);
                end
            end
        end
        checks++;
        if (w_retire_cnt !== 4'd0 || w_err_dup !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_zero: retire_cnt=%0d err_dup=%b expected 0 0", w_retire_cnt, w_err_dup);
        end
        w_oq_empty = 1'b1;
    endtask

    initial begin
        $display("[TB] starting commit_sequencer tests");
        test_reset();
        test_single_retire();
        test_out_of_order();
        test_zero_dest();
        test_errors();
        test_commit_cdb_collision();
        test_reset_mid_commit();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
